// File: rtl/uart_frame_tx_if.sv
// Byte-handshake bundle between the frame requester, the framer and uart_tx.
interface uart_frame_tx_if #(parameter int NBYTES = 4);
  logic                  send;
  logic [8*NBYTES-1:0]   payload;
  logic                  tx_done_tick;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output send, payload, tx_done_tick,
    input  tx_start, tx_data, busy, frame_done
  );

  modport slave (
    input  send, payload, tx_done_tick,
    output tx_start, tx_data, busy, frame_done
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Frames a captured payload as SYNC, payload bytes LSB-first, XOR checksum,
// and feeds it byte by byte to uart_tx over the tx_start/tx_done_tick handshake.
//   state   | meaning
//   S_IDLE  | waiting for send
//   S_ISSUE | tx_start pulse for byte idx
//   S_WAIT  | waiting for tx_done_tick of byte idx
module uart_frame_tx #(
  parameter int         NBYTES = 4,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input logic            pclk,
  input logic            rst,
  uart_frame_tx_if.slave bus
);
  localparam int IW = $clog2(NBYTES + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          csum_q, csum_d;
  logic [8*NBYTES-1:0] shadow_q, shadow_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                frame_done_q, frame_done_d;
  logic [IW-1:0]       next_idx;

  function automatic logic [7:0] byte_at(input logic [IW-1:0]       i,
                                         input logic [8*NBYTES-1:0] sh,
                                         input logic [7:0]          cs);
    logic [7:0] b;
    b = SYNC;
    if (i == LAST_IDX) begin
      b = cs;
    end else begin
      for (int k = 0; k < NBYTES; k++) begin
        if (int'(i) == k + 1) b = sh[8*k +: 8];
      end
    end
    return b;
  endfunction

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      csum_q       <= '0;
      shadow_q     <= '0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      shadow_q     <= shadow_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    shadow_d     = shadow_q;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    next_idx     = idx_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.send) begin
          shadow_d  = bus.payload;
          idx_d     = '0;
          csum_d    = '0;
          tx_data_d = SYNC;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // tx_data_q already holds byte(idx), so it is what goes into the checksum
        if (idx_q != '0 && idx_q != LAST_IDX) csum_d = csum_q ^ tx_data_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done_tick) begin
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            idx_d     = next_idx;
            tx_data_d = byte_at(next_idx, shadow_q, csum_q);
            state_d   = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tx_start   = (state_q == S_ISSUE);
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = frame_done_q;
endmodule
